acc_tx: RTL
===========

# acc_tx

Downstream readout stage for the 128-bit accumulator block. On a start pulse it walks the accumulator's byte-select input through all bytes, most-significant first, and sends each byte out as an 8N1 UART frame on a single serial line. It sits between the accumulator's `sel`/`data` read port and the board's TX pin, returning accumulated results to the host.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clocks per UART bit (115200 baud at 50 MHz); legal ≥ 2.
- `NBYTES`, default 16: bytes per dump; `sel` width is fixed at 4, so legal range is 1..16.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `data`  in  8  accumulator byte selected by `sel`.
- `sel`  out  4  byte select driven to the accumulator.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high from the cycle after an accepted `start` until the dump completes.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation

- States:
  - IDLE: `tx=1`, `busy=0`. On `start`: `sel<=NBYTES-1`, go to LOAD.
  - LOAD: one cycle. `shreg<=data`, `tx<=0`, go to START.
  - START: hold `tx=0` for `CLKS_PER_BIT` cycles, then `tx<=shreg[0]`, go to DATA.
  - DATA: 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles; shift right after each bit. After bit 7, `tx<=1` and go to STOP.
  - STOP: hold `tx=1` for `CLKS_PER_BIT` cycles, then:
    - if `sel!=0`: `sel<=sel-1`, go to LOAD;
    - else pulse `done`, `busy<=0`, go to IDLE.
- Counters:
  - baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1 and restarts on every bit boundary.
  - bit counter: 3 bits.
- Byte sampling:
  - `data` is sampled only in LOAD, one cycle after `sel` changes, so the accumulator's `sel`→`data` path may be combinational.
  - Each byte reflects the accumulator value at its own LOAD cycle. Dump coherency is the controller's responsibility: do not pulse `add` while `busy` is high.
- Boundary conditions:
  - `start` while `busy`: ignored, with no effect on the frame in progress.
  - `start` held high continuously: a new dump begins on the IDLE cycle following `done`.
  - `rst` mid-frame: the next edge forces IDLE, `tx=1`, `busy=0`, `done=0`, `sel=0` and clears all counters. No partial stop bit is appended.
  - `rst` and `start` in the same cycle: `rst` wins.
  - `sel` reaching 0 terminates the dump; it never wraps to 15.

## Timing

- Reset values: `tx=1`, `busy=0`, `done=0`, `sel=0`, state IDLE, counters 0.
- `start` high at edge N:
  - `busy=1` and `sel=NBYTES-1` after edge N;
  - `tx` falls after edge N+1.
- Each frame is `10*CLKS_PER_BIT` cycles of `tx`: 1 start, 8 data, 1 stop.
- Between frames there is one extra `tx=1` cycle (the LOAD state), so the byte period is `10*CLKS_PER_BIT+1` cycles.
- `done` is high for exactly one cycle, the cycle after the final stop bit's last clock. `busy` falls in that same cycle.
- Total from `start` edge to `done`: `1 + NBYTES*(10*CLKS_PER_BIT+1)` cycles.
- `sel` is stable for the whole of each frame and changes only on the STOP→LOAD transition.

## Test plan

All scenarios use `CLKS_PER_BIT=4`. The bench models the accumulator as a combinational 16-byte array indexed by `sel`, and decodes `tx` by sampling at bit centres.

- Reset: assert `rst` for 3 cycles with `start=1` → `tx=1`, `busy=0`, `done=0`, `sel=0` throughout; no frame after release until `start` is pulsed again.
- Single dump: array holds bytes 0x00..0x0F at indices 0..15; pulse `start` → decoded stream is 0x0F, 0x0E, …, 0x00; `done` pulses exactly 657 cycles after `start`; `busy` high for 656 cycles.
- Bit order and framing: `NBYTES=1`, byte 0 = 0xA5 → `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; `tx` falls 2 cycles after `start`.
- `start` during busy: pulse `start` again mid-dump at cycle 100 → output identical to the single-dump scenario; exactly one `done`.
- Reset mid-frame: assert `rst` during the DATA state of byte 5 → next cycle `tx=1`, `busy=0`; a fresh `start` produces a complete, correct 16-byte dump beginning with 0x0F.
- Back-to-back: hold `start=1` continuously → second dump's start bit begins 2 cycles after the first `done`; both dumps decode correctly.

Source files
------------

// File: rtl/acc_tx.sv
// acc_tx: reads the accumulator out MSB byte first and sends each byte as an 8N1 UART frame.
// Latency: tx falls two edges after start is raised; a dump takes 1 + NBYTES*(10*CLKS_PER_BIT+1) cycles.
// Backpressure: none; start is ignored while busy, and data is sampled once per byte in LOAD.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  dump request, sampled in IDLE only
//   data   accumulator byte currently selected by sel
//   sel    byte select to the accumulator, NBYTES-1 down to 0
//   tx     UART serial output, idle high
//   busy   high while a dump is in progress
//   done   one-cycle pulse after the final stop bit
module acc_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NBYTES       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic [3:0] sel,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state;
   logic [BW-1:0]   baud;
   logic [2:0]      bitc;
   logic [7:0]      shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         baud  <= '0;
         bitc  <= '0;
         shreg <= '0;
         sel   <= '0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx   <= 1'b1;
               baud <= '0;
               bitc <= '0;
               if (start) begin
                  sel   <= 4'(NBYTES - 1);
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end

            // sel settled last cycle, so data is valid even through a
            // combinational select path in the accumulator.
            LOAD: begin
               shreg <= data;
               tx    <= 1'b0;
               baud  <= '0;
               state <= START;
            end

            START: begin
               if (baud == BAUD_MAX) begin
                  baud  <= '0;
                  bitc  <= '0;
                  tx    <= shreg[0];
                  state <= DATA;
               end else begin
                  baud <= baud + BW'(1);
               end
            end

            // shreg[0] is the bit on the line; at each boundary the next
            // bit (shreg[1]) is launched while the register shifts right.
            DATA: begin
               if (baud == BAUD_MAX) begin
                  baud <= '0;
                  if (bitc == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx    <= shreg[1];
                     shreg <= shreg >> 1;
                     bitc  <= bitc + 3'd1;
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end

            // sel only moves here, so it is stable across every frame and
            // stops at 0 rather than wrapping.
            STOP: begin
               if (baud == BAUD_MAX) begin
                  baud <= '0;
                  if (sel != 4'd0) begin
                     sel   <= sel - 4'd1;
                     state <= LOAD;
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
